data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of RAM word count (256 x 32-bit words).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port mem_addr  input  32  byte address from the CPU.
REQ-005 SHALL have port mem_write_data  input  32  store data from the CPU.
REQ-006 SHALL have port wren  input  1  store enable from the CPU.
REQ-007 SHALL have port mem_read_data  output  32  load data returned to the CPU.
REQ-008 SHALL have port led  output  10  memory-mapped LED register.
REQ-009 SHALL have port busy  output  1  high while the RAM clear sequence runs.

Function
REQ-010 SHALL decode addresses as follows: mem_addr[31:28]==0 selects RAM, word index mem_addr[DEPTH_LOG2+1:2], upper bits ignored; 0x8000_0000 selects LED; 0x8000_0004 selects STATUS; 0x8000_0008 selects TIMER; all other addresses are unmapped.
REQ-011 SHALL ignore mem_addr[1:1:0] (word access only, no misalignment error).
REQ-012 SHALL register mem_read_data: data for the address presented in cycle N appears after edge N and holds until the next edge.
REQ-013 SHALL perform a RAM or register write at the rising edge when wren=1, busy=0, and the address is mapped and writable.
REQ-014 SHALL return old contents on read-during-write to the same RAM word (read-first); the new value is visible on the next access.
REQ-015 SHALL load led from mem_write_data[9:0] on an LED write; an LED read returns {22'b0, led}.
REQ-016 SHALL return {31'b0, busy} on a STATUS read; STATUS writes are ignored.
REQ-017 SHALL return 0 on unmapped reads and ignore unmapped writes.
REQ-018 SHALL implement states CLEAR and IDLE: CLEAR writes 0 to RAM word clr_ptr each cycle and increments clr_ptr; after word 2^DEPTH_LOG2-1 is cleared, the next state is IDLE.
REQ-019 SHALL drive busy=1 exactly while in CLEAR; in CLEAR, RAM reads return 0 and all CPU writes (RAM and MMIO) are dropped.
REQ-020 SHALL keep busy high for exactly 2^DEPTH_LOG2 cycles after rst is released.

Reset
REQ-021 SHALL, at any edge with rst=0, set state=CLEAR, clr_ptr=0, mem_read_data=0, led=0, busy=1, and TIMER=0 when present.
REQ-022 SHALL restart clearing from word 0 when reset is asserted mid-CLEAR or mid-operation.

Configuration
REQ-023 SHALL compile the TIMER register only when macro DATA_MEM_TIMER_EN is defined.
REQ-024 SHALL, with DATA_MEM_TIMER_EN defined, keep a 32-bit counter that increments every cycle out of reset (including during CLEAR) and wraps 0xFFFF_FFFF to 0.
REQ-025 SHALL, with DATA_MEM_TIMER_EN defined, have a TIMER write in IDLE load mem_write_data, which takes precedence over the increment in that cycle.
REQ-026 SHALL, without DATA_MEM_TIMER_EN, treat 0x8000_0008 as unmapped (reads 0, writes ignored).

Structure
REQ-027 SHALL place the address-map constants (RAM region, LED/STATUS/TIMER addresses) and the state enum {CLEAR, IDLE} in shared package data_mem_pkg.
REQ-028 SHALL instantiate one sub-module, dmem_ram: single-port synchronous read-first RAM with a width-32 data path, depth 2^DEPTH_LOG2 words, and a write-enable port.
REQ-029 SHALL keep address decode, FSM, MMIO registers, and the read-data mux in data_mem.

Verification
REQ-030 SHALL cover this scenario: release rst, read STATUS each cycle -> 1 for 256 cycles, then 0; RAM read of 0x0000_0010 -> 0.
REQ-031 SHALL cover this scenario: in IDLE, write 0xDEADBEEF to 0x0000_0020, then read 0x0000_0020 -> 0xDEADBEEF one cycle after the address; read 0x0000_0420 (alias) -> 0xDEADBEEF.
REQ-032 SHALL cover this scenario: write 0x1234 to 0x0000_0040 while also reading it that cycle -> old value 0; the next read -> 0x0000_1234.
REQ-033 SHALL cover this scenario: write 0x3FF to 0x8000_0000 -> led=0x3FF; read -> 0x0000_03FF; write during CLEAR -> led unchanged; read 0x9000_0000 -> 0.
REQ-034 SHALL cover this scenario: with DATA_MEM_TIMER_EN, write 0xFFFF_FFFE to 0x8000_0008 -> reads 2 and 3 cycles later give 0xFFFF_FFFF and 0 (wrap); without the macro -> reads 0.
REQ-035 SHALL cover this scenario: assert rst for 1 cycle at clr_ptr=100 -> busy stays high a further 256 cycles; led=0 and mem_read_data=0 after that edge.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared address map and FSM state type for the data memory block.
package data_mem_pkg;

    // Any address whose top nibble is zero lands in RAM.
    localparam logic [3:0]  RAM_REGION  = 4'h0;
    localparam logic [31:0] LED_ADDR    = 32'h8000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h8000_0004;
    localparam logic [31:0] TIMER_ADDR  = 32'h8000_0008;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, read-first: a read of the word being written
// returns the contents from before the write.
module dmem_ram #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Write and registered read share one address; rdata samples old contents.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem.sv
// Data memory with RAM, LED/STATUS MMIO registers and a clear-on-reset
// sequence. Optional free-running TIMER register when DATA_MEM_TIMER_EN is
// defined; without it the TIMER address reads as unmapped.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic        wren,
    output logic [31:0] mem_read_data,
    output logic [9:0]  led,
    output logic        busy
);

    state_t                state, state_nxt;
    logic [DEPTH_LOG2-1:0] clr_ptr;

    logic                  sel_ram, sel_led, sel_status;
    logic                  cpu_we;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [31:0]           ram_wdata, ram_rdata;
    logic [31:0]           mmio_rd, mmio_q;
    logic                  ram_sel_q;

    // Word-granular decode: the low two address bits never take part.
    assign sel_ram    = (mem_addr[31:28] == RAM_REGION);
    assign sel_led    = (mem_addr[31:2] == LED_ADDR[31:2]);
    assign sel_status = (mem_addr[31:2] == STATUS_ADDR[31:2]);

    assign busy   = (state == CLEAR);
    assign cpu_we = wren & ~busy;

    // While clearing, the RAM port belongs to the clear sequencer.
    assign ram_we    = rst & (busy | (cpu_we & sel_ram));
    assign ram_addr  = busy ? clr_ptr : mem_addr[DEPTH_LOG2+1:2];
    assign ram_wdata = busy ? 32'd0 : mem_write_data;

    dmem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (32)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // State register and clear pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // Leave CLEAR once the last word has been zeroed.
    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_ptr == '1) state_nxt = IDLE;
    end

    // LED register: only CPU writes in IDLE take effect.
    always_ff @(posedge clk) begin
        if (!rst)                   led <= '0;
        else if (cpu_we && sel_led) led <= mem_write_data[9:0];
    end

`ifdef DATA_MEM_TIMER_EN
    logic        sel_timer;
    logic [31:0] timer;

    assign sel_timer = (mem_addr[31:2] == TIMER_ADDR[31:2]);

    // Free-running counter; a CPU write wins over the increment.
    always_ff @(posedge clk) begin
        if (!rst)                     timer <= '0;
        else if (cpu_we && sel_timer) timer <= mem_write_data;
        else                          timer <= timer + 32'd1;
    end
`endif

    // MMIO read value for the current address; unmapped reads give zero.
    always_comb begin
        mmio_rd = '0;
        if (sel_led)    mmio_rd = {22'b0, led};
        if (sel_status) mmio_rd = {31'b0, busy};
`ifdef DATA_MEM_TIMER_EN
        if (sel_timer)  mmio_rd = timer;
`endif
    end

    // Register the read source so RAM and MMIO data align at the same edge.
    // RAM data is masked to zero while clearing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ram_sel_q <= 1'b0;
            mmio_q    <= '0;
        end else begin
            ram_sel_q <= sel_ram & ~busy;
            mmio_q    <= mmio_rd;
        end
    end

    assign mem_read_data = ram_sel_q ? ram_rdata : mmio_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem. Expected TIMER behaviour follows
// DATA_MEM_TIMER_EN when the bench is compiled with the same define.
module tb_data_mem;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        wren;
    logic [31:0] mem_read_data;
    logic [9:0]  led;
    logic        busy;

    int ncmp  = 0;
    int nfail = 0;

    localparam logic [31:0] A_LED    = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;
    localparam logic [31:0] A_TIMER  = 32'h8000_0008;

    data_mem #(.DEPTH_LOG2(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .wren           (wren),
        .mem_read_data  (mem_read_data),
        .led            (led),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a);
        mem_addr = a;
        wren     = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_addr       = a;
        mem_write_data = d;
        wren           = 1'b1;
        tick();
        wren           = 1'b0;
    endtask

    initial begin
        rst = 1'b0; wren = 1'b0; mem_addr = '0; mem_write_data = '0;
        @(negedge clk);
        repeat (3) tick();
        check("reset_busy", {31'b0, busy}, 32'd1);
        check("reset_led", {22'b0, led}, 32'd0);
        check("reset_rdata", mem_read_data, 32'd0);

        // Clear after power-up: STATUS reads 1 for 256 cycles, then 0.
        rst = 1'b1;
        mem_addr = A_STATUS;
        for (int k = 1; k <= 256; k++) begin
            check("clear_busy", {31'b0, busy}, 32'd1);
            tick();
            check("status_rd_busy", mem_read_data, 32'd1);
        end
        check("clear_done_busy", {31'b0, busy}, 32'd0);
        mem_addr = A_TIMER;
        tick();
`ifdef DATA_MEM_TIMER_EN
        check("timer_after_clear", mem_read_data, 32'd256);
`else
        check("timer_unmapped", mem_read_data, 32'd0);
`endif
        rd(A_STATUS);
        check("status_rd_idle", mem_read_data, 32'd0);
        rd(32'h0000_0010);
        check("ram_cleared", mem_read_data, 32'd0);

        // Write then read back, with upper-address alias and ignored low bits.
        wr(32'h0000_0020, 32'hDEAD_BEEF);
        check("wr_cycle_old", mem_read_data, 32'd0);
        rd(32'h0000_0020);
        check("ram_rd", mem_read_data, 32'hDEAD_BEEF);
        rd(32'h0000_0420);
        check("ram_alias", mem_read_data, 32'hDEAD_BEEF);
        rd(32'h0000_0023);
        check("ram_lowbits", mem_read_data, 32'hDEAD_BEEF);

        // Read-during-write returns old contents.
        wr(32'h0000_0040, 32'h0000_1234);
        check("rdw_old", mem_read_data, 32'd0);
        rd(32'h0000_0040);
        check("rdw_new", mem_read_data, 32'h0000_1234);

        // LED, STATUS and unmapped accesses.
        wr(A_LED, 32'hFFFF_FFFF);
        check("led_wr", {22'b0, led}, 32'h0000_03FF);
        rd(A_LED);
        check("led_rd", mem_read_data, 32'h0000_03FF);
        wr(A_STATUS, 32'h0000_0001);
        rd(A_STATUS);
        check("status_wr_ignored", mem_read_data, 32'd0);
        wr(32'h9000_0000, 32'h5555_5555);
        rd(32'h9000_0000);
        check("unmapped_rd", mem_read_data, 32'd0);
        check("unmapped_wr_led", {22'b0, led}, 32'h0000_03FF);

        // TIMER load and wrap.
        wr(A_TIMER, 32'hFFFF_FFFE);
        rd(A_TIMER);
        rd(A_TIMER);
`ifdef DATA_MEM_TIMER_EN
        check("timer_max", mem_read_data, 32'hFFFF_FFFF);
`else
        check("timer_unmapped_a", mem_read_data, 32'd0);
`endif
        rd(A_TIMER);
`ifdef DATA_MEM_TIMER_EN
        check("timer_wrap", mem_read_data, 32'd0);
`else
        check("timer_unmapped_b", mem_read_data, 32'd0);
`endif

        // Reset mid-operation clears LED and read data.
        mem_addr = A_LED;
        tick();
        check("pre_reset_rd", mem_read_data, 32'h0000_03FF);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midop_led", {22'b0, led}, 32'd0);
        check("midop_rdata", mem_read_data, 32'd0);
        check("midop_busy", {31'b0, busy}, 32'd1);

        // Writes during CLEAR are dropped; RAM reads give 0 (clr_ptr 0..2).
        wr(A_LED, 32'h0000_02AA);
        check("clear_led_drop", {22'b0, led}, 32'd0);
        wr(32'h0000_0080, 32'h5555_5555);
        rd(32'h0000_0020);
        check("clear_ram_rd0", mem_read_data, 32'd0);

        // Reset again at clr_ptr = 100.
        mem_addr = A_STATUS;
        repeat (97) tick();
        check("clear_status", mem_read_data, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midclr_led", {22'b0, led}, 32'd0);
        check("midclr_rdata", mem_read_data, 32'd0);
        for (int k = 1; k <= 256; k++) begin
            check("reclear_busy", {31'b0, busy}, 32'd1);
            tick();
        end
        check("reclear_done", {31'b0, busy}, 32'd0);
        rd(32'h0000_0080);
        check("clear_ram_drop", mem_read_data, 32'd0);
        rd(32'h0000_0020);
        check("reclear_ram", mem_read_data, 32'd0);
        rd(32'h0000_0040);
        check("reclear_ram2", mem_read_data, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
